// File: rtl/microwave_cu_gen2_pkg.sv
// Shared constants and state encoding for the microwave control unit.
package microwave_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] SELECT = 3'd1;
  localparam logic [STATE_W-1:0] RUN    = 3'd2;
  localparam logic [STATE_W-1:0] PAUSE  = 3'd3;
  localparam logic [STATE_W-1:0] FINISH = 3'd4;

  localparam int FIELD_SEC = 0;
  localparam int FIELD_MIN = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = IDLE,
    ST_SELECT = SELECT,
    ST_RUN    = RUN,
    ST_PAUSE  = PAUSE,
    ST_FINISH = FINISH
  } state_t;

endpackage

// File: rtl/microwave_cu_gen2_if.sv
// Control-unit signal bundle between the input conditioning, the timer datapath and the controller.
interface microwave_cu_gen2_if
  import microwave_pkg::*;
#(
  parameter int NUM_FIELDS = 2
);

  logic                  enable;
  logic                  door_open;
  logic                  btn_sel;
  logic                  btn_start;
  logic                  finish;
  logic                  time_zero;
  logic                  tick;
  logic [NUM_FIELDS-1:0] sel;
  logic                  run;
  logic                  paused;
  logic                  toggle;
  logic [STATE_W-1:0]    state;

  modport master (
    output enable, door_open, btn_sel, btn_start, finish, time_zero, tick,
    input  sel, run, paused, toggle, state
  );

  modport slave (
    input  enable, door_open, btn_sel, btn_start, finish, time_zero, tick,
    output sel, run, paused, toggle, state
  );

endinterface

// File: rtl/microwave_cu_gen2_btn_edge.sv
// Rising-edge detector; history resets high so a button held through reset never fires.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/microwave_cu_gen2.sv
// Microwave cook-cycle controller: field select, run/pause/resume, door interlock, timed alarm.
//   state  | meaning
//   IDLE   | powered off / waiting for enable
//   SELECT | editing time field idx, start allowed if door closed and time nonzero
//   RUN    | timer counting down
//   PAUSE  | cycle suspended, time retained
//   FINISH | alarm active until start press or ALARM_TICKS ticks
module microwave_cu_gen2
  import microwave_pkg::*;
#(
  parameter  int NUM_FIELDS  = 2,
  parameter  int ALARM_TICKS = 5,
  localparam int IDX_W       = $clog2(NUM_FIELDS),
  localparam int ALM_W       = $clog2(ALARM_TICKS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  microwave_cu_gen2_if.slave  bus
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ALM_W-1:0]   alm_q, alm_d;
  logic               sel_edge, start_edge;

  btn_edge u_sel_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.btn_sel),
    .rise  (sel_edge)
  );

  btn_edge u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.btn_start),
    .rise  (start_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      alm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      alm_q   <= alm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    alm_d   = alm_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = ST_SELECT;
          idx_d   = '0;
        end
      end
      ST_SELECT: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (start_edge && !bus.door_open && !bus.time_zero) begin
          state_d = ST_RUN;
        end else if (sel_edge) begin
          idx_d = (idx_q == IDX_W'(NUM_FIELDS - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (bus.finish) begin
          state_d = ST_FINISH;
          alm_d   = '0;
        end else if (bus.door_open || start_edge) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (!bus.enable || sel_edge) begin
          state_d = ST_IDLE;
        end else if (start_edge && !bus.door_open) begin
          state_d = ST_RUN;
        end
      end
      ST_FINISH: begin
        if (start_edge) begin
          state_d = ST_IDLE;
        end else if (bus.tick) begin
          if (alm_q == ALM_W'(ALARM_TICKS - 1)) state_d = ST_IDLE;
          // saturate rather than wrap in case the terminal compare is ever missed
          if (alm_q != ALM_W'(ALARM_TICKS)) alm_d = alm_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.sel    = (state_q == ST_SELECT) ? (NUM_FIELDS'(1) << idx_q) : '0;
  assign bus.run    = (state_q == ST_RUN);
  assign bus.paused = (state_q == ST_PAUSE);
  assign bus.toggle = (state_q == ST_FINISH);
  assign bus.state  = state_q;

endmodule

// File: tb/tb_microwave_cu_gen2.sv
// Scoreboard bench for microwave_cu_gen2 with NUM_FIELDS=3, ALARM_TICKS=5.
module tb_microwave_cu_gen2;
  import microwave_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] sel;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   step_no;
  exp_t sb_q[$];

  microwave_cu_gen2_if #(.NUM_FIELDS(3)) bus ();

  microwave_cu_gen2 #(.NUM_FIELDS(3), .ALARM_TICKS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s step %0d: got %0h expected %0h", tag, step_no, obs, exp);
    else
      n_pass++;
  endtask

  // Push the expectation for the coming edge, then compare once the DUT has moved.
  task automatic step(input logic [2:0] est, input logic [2:0] esel);
    exp_t e;
    e.st  = est;
    e.sel = esel;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("state",  32'(bus.state),  32'(e.st));
      chk("sel",    32'(bus.sel),    32'(e.sel));
      chk("run",    32'(bus.run),    32'(e.st == RUN));
      chk("paused", 32'(bus.paused), 32'(e.st == PAUSE));
      chk("toggle", 32'(bus.toggle), 32'(e.st == FINISH));
    end
  endtask

  task automatic press_start(input logic [2:0] est, input logic [2:0] esel);
    bus.btn_start = 1'b1;
    step(est, esel);
    bus.btn_start = 1'b0;
  endtask

  task automatic press_sel(input logic [2:0] est, input logic [2:0] esel);
    bus.btn_sel = 1'b1;
    step(est, esel);
    bus.btn_sel = 1'b0;
  endtask

  // From SELECT with a valid time: run, finish, then n_ticks alarm ticks.
  task automatic run_and_finish(input int n_ticks);
    press_start(RUN, 3'b000);
    step(RUN, 3'b000);
    bus.finish = 1'b1;
    step(FINISH, 3'b000);
    bus.finish = 1'b0;
    for (int k = 1; k <= n_ticks; k++) begin
      bus.tick = 1'b1;
      step((k == 5) ? IDLE : FINISH, 3'b000);
      bus.tick = 1'b0;
      step((k == 5) ? SELECT : FINISH, (k == 5) ? 3'b001 : 3'b000);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    step_no       = 0;
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.door_open = 1'b0;
    bus.btn_sel   = 1'b0;
    bus.btn_start = 1'b1;
    bus.finish    = 1'b0;
    bus.time_zero = 1'b0;
    bus.tick      = 1'b0;

    #12;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_sel",   32'(bus.sel),   32'd0);
    chk("rst_run",   32'(bus.run),   32'd0);
    #10 rst_n = 1'b1;

    // start held through reset must not produce an edge
    step(IDLE, 3'b000);
    bus.enable = 1'b1;
    step(SELECT, 3'b001);
    step(SELECT, 3'b001);
    bus.btn_start = 1'b0;
    step(SELECT, 3'b001);

    // field walk with wrap
    press_sel(SELECT, 3'b010); step(SELECT, 3'b010);
    press_sel(SELECT, 3'b100); step(SELECT, 3'b100);
    press_sel(SELECT, 3'b001); step(SELECT, 3'b001);

    // start guards
    bus.time_zero = 1'b1;
    press_start(SELECT, 3'b001); step(SELECT, 3'b001);
    bus.time_zero = 1'b0;
    bus.door_open = 1'b1;
    press_start(SELECT, 3'b001); step(SELECT, 3'b001);
    bus.door_open = 1'b0;
    press_sel(SELECT, 3'b010); step(SELECT, 3'b010);

    // simultaneous start and select: start wins
    bus.btn_sel = 1'b1;
    press_start(RUN, 3'b000);
    bus.btn_sel = 1'b0;
    step(RUN, 3'b000);

    // door pause, close alone holds, start resumes
    bus.door_open = 1'b1; step(PAUSE, 3'b000);
    bus.door_open = 1'b0; step(PAUSE, 3'b000);
    press_start(RUN, 3'b000);   step(RUN, 3'b000);
    press_start(PAUSE, 3'b000); step(PAUSE, 3'b000);
    press_sel(IDLE, 3'b000);
    step(SELECT, 3'b001);

    // finish wins over door, full alarm timeout
    press_start(RUN, 3'b000);
    step(RUN, 3'b000);
    bus.finish    = 1'b1;
    bus.door_open = 1'b1;
    step(FINISH, 3'b000);
    bus.finish    = 1'b0;
    bus.door_open = 1'b0;
    step(FINISH, 3'b000);
    for (int k = 1; k <= 5; k++) begin
      bus.tick = 1'b1;
      step((k == 5) ? IDLE : FINISH, 3'b000);
      bus.tick = 1'b0;
      step((k == 5) ? SELECT : FINISH, (k == 5) ? 3'b001 : 3'b000);
    end

    // start cuts the alarm short; count restarts on the next entry
    run_and_finish(2);
    press_start(IDLE, 3'b000);
    step(SELECT, 3'b001);
    run_and_finish(5);

    // async reset between edges mid-RUN
    press_sel(SELECT, 3'b010); step(SELECT, 3'b010);
    press_start(RUN, 3'b000);
    step(RUN, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_run",   32'(bus.run),   32'd0);
    chk("async_state", 32'(bus.state), 32'd0);
    #2 rst_n = 1'b1;
    step(SELECT, 3'b001);

    // enable drop in PAUSE
    press_start(RUN, 3'b000);   step(RUN, 3'b000);
    press_start(PAUSE, 3'b000); step(PAUSE, 3'b000);
    bus.enable = 1'b0;
    step(IDLE, 3'b000);
    step(IDLE, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
